// File: rtl/io_input_conditioner.sv
// Input-pin front end: per-pin synchroniser + debouncer, press pulses, and a
// small press-event FIFO drained by a valid/ready consumer.

module io_ic_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic rise_set
);
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;
    logic                   term;

    assign s        = sync[SYNC_STAGES-1];
    assign term     = (s != level) && (cnt == CNT_W'(DB_CYCLES - 1));
    // Next-cycle rise, so the pending mask can latch on the same edge as rise.
    assign rise_set = term && !level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            if (s == level || term)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (term)
                level <= ~level;
            rise <= rise_set;
        end
    end
endmodule

module io_input_conditioner #(
    parameter int N_IN        = 9,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int IDX_W       = $clog2(N_IN)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic [N_IN-1:0]  pin_i,
    output logic [N_IN-1:0]  level_o,
    output logic [N_IN-1:0]  rise_o,
    output logic             evt_valid_o,
    output logic [IDX_W-1:0] evt_data_o,
    input  logic             evt_ready_i,
    output logic             evt_overflow_o,
    input  logic             clear_ovf_i
);
    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam int AW    = $clog2(FIFO_DEPTH);

    logic [N_IN-1:0]  rise_set;
    logic [N_IN-1:0]  pend;
    logic [N_IN-1:0]  push_oh;
    logic [IDX_W-1:0] push_idx;
    logic             push, pop, full, empty, avail;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [IDX_W-1:0] mem [FIFO_DEPTH];

    for (genvar g = 0; g < N_IN; g++) begin : g_lane
        io_ic_lane #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_lane (
            .clk     (wb_clk_i),
            .rst_n   (wb_rst_ni),
            .pin     (pin_i[g]),
            .level   (level_o[g]),
            .rise    (rise_o[g]),
            .rise_set(rise_set[g])
        );
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && evt_ready_i;
    assign avail = !full || pop;
    assign push  = (|pend) && avail;

    // Lowest pending index wins; descending scan leaves the smallest set bit.
    always_comb begin
        push_idx = '0;
        for (int i = N_IN - 1; i >= 0; i--)
            if (pend[i])
                push_idx = IDX_W'(i);
        push_oh = push ? (N_IN'(1) << push_idx) : '0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            pend           <= '0;
            evt_overflow_o <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
        end else begin
            // New press on the same edge as a push keeps the bit set.
            pend <= (pend & ~push_oh) | rise_set;
            if (|(rise_set & pend & ~push_oh))
                evt_overflow_o <= 1'b1;
            else if (clear_ovf_i)
                evt_overflow_o <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= push_idx;
    end

    assign evt_valid_o = !empty;
    assign evt_data_o  = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner: stimulus pushes expected press
// events into a queue, a negedge monitor pops and compares on each handshake.

module tb_io_input_conditioner;
    localparam int N = 9;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ready = 1'b0;
    logic         clr = 1'b0;
    logic [N-1:0] pin = '0;
    logic [N-1:0] level_o, rise_o;
    logic         evt_valid_o, evt_overflow_o;
    logic [3:0]   evt_data_o;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_q[$];

    io_input_conditioner dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .pin_i         (pin),
        .level_o       (level_o),
        .rise_o        (rise_o),
        .evt_valid_o   (evt_valid_o),
        .evt_data_o    (evt_data_o),
        .evt_ready_i   (ready),
        .evt_overflow_o(evt_overflow_o),
        .clear_ovf_i   (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until level_o[idx]==val, bounded; returns the number of edges.
    task automatic wait_level(input int idx, input logic val, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (level_o[idx] !== val && n < 60);
    endtask

    always @(negedge clk) begin
        if (rst_n && evt_valid_o && ready) begin
            if (exp_q.size() == 0) chk("evt_unexpected", int'(evt_data_o), -1);
            else chk("evt_data", int'(evt_data_o), exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int n, bad, rises;
        // Reset state
        tick(); tick();
        chk("rst_level", int'(level_o), 0);
        chk("rst_rise", int'(rise_o), 0);
        chk("rst_valid", int'(evt_valid_o), 0);
        chk("rst_data", int'(evt_data_o), 0);
        chk("rst_ovf", int'(evt_overflow_o), 0);
        rst_n = 1'b1;

        // 1: single press, consumer ready
        ready = 1'b1;
        pin[0] = 1'b1;
        exp_q.push_back(0);
        wait_level(0, 1'b1, n);
        chk("t1_latency", n, 18);
        chk("t1_rise", int'(rise_o), 1);
        tick();
        chk("t1_valid", int'(evt_valid_o), 1);
        chk("t1_data", int'(evt_data_o), 0);
        chk("t1_rise_pulse", int'(rise_o), 0);
        tick();
        chk("t1_popped", int'(evt_valid_o), 0);

        // 2: bouncing pin 2, then held
        bad = 0; rises = 0;
        for (int c = 0; c < 40; c++) begin
            pin[2] = ((c / 5) % 2 == 0);
            tick();
            bad += int'(level_o[2]);
            rises += int'(rise_o[2]);
        end
        pin[2] = 1'b1;
        exp_q.push_back(2);
        n = 0;
        do begin
            tick(); n++;
            rises += int'(rise_o[2]);
        end while (!level_o[2] && n < 60);
        for (int k = 0; k < 3; k++) begin
            tick();
            rises += int'(rise_o[2]);
        end
        chk("t2_bounce_level", bad, 0);
        chk("t2_latency", n, 18);
        chk("t2_one_rise", rises, 1);

        // 3: simultaneous presses drain in index order
        ready = 1'b0;
        pin[3] = 1'b1; pin[7] = 1'b1; pin[8] = 1'b1;
        exp_q.push_back(3); exp_q.push_back(7); exp_q.push_back(8);
        wait_level(3, 1'b1, n);
        chk("t3_latency", n, 18);
        chk("t3_rise", int'(rise_o), 'h188);
        tick();
        chk("t3_valid", int'(evt_valid_o), 1);
        chk("t3_head", int'(evt_data_o), 3);
        tick(); tick();
        chk("t3_head_held", int'(evt_data_o), 3);
        ready = 1'b1;
        tick(); tick(); tick();
        chk("t3_drained", int'(evt_valid_o), 0);

        // 6: release all debounced-high pins
        pin = '0;
        bad = 0;
        for (int k = 0; k < 17; k++) begin
            tick();
            bad += (rise_o != '0) ? 1 : 0;
        end
        chk("t6_level_before", int'(level_o), 'h18D);
        tick();
        chk("t6_level_after", int'(level_o), 0);
        chk("t6_no_rise", bad + int'(rise_o != '0), 0);
        chk("t6_no_evt", int'(evt_valid_o), 0);
        chk("t6_ovf", int'(evt_overflow_o), 0);

        // 4: FIFO full, pending bit, overflow
        ready = 1'b0;
        pin[4:0] = 5'h1F;
        for (int k = 0; k < 5; k++) exp_q.push_back(k);
        wait_level(4, 1'b1, n);
        chk("t4_latency", n, 18);
        chk("t4_rise", int'(rise_o), 'h1F);
        repeat (5) tick();
        chk("t4_full_valid", int'(evt_valid_o), 1);
        chk("t4_full_head", int'(evt_data_o), 0);
        chk("t4_no_ovf", int'(evt_overflow_o), 0);
        pin[4] = 1'b0;
        wait_level(4, 1'b0, n);
        chk("t4_fall_latency", n, 18);
        pin[4] = 1'b1;
        wait_level(4, 1'b1, n);
        chk("t4_repress_rise", int'(rise_o[4]), 1);
        chk("t4_ovf_set", int'(evt_overflow_o), 1);
        tick();
        chk("t4_ovf_sticky", int'(evt_overflow_o), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t4_ovf_clear", int'(evt_overflow_o), 0);
        ready = 1'b1;
        repeat (6) tick();
        chk("t4_drained", int'(evt_valid_o), 0);

        // 5: reset with queued events and pin 5 mid-count
        ready = 1'b0;
        pin[6] = 1'b1; pin[7] = 1'b1;
        exp_q.push_back(6); exp_q.push_back(7);
        wait_level(6, 1'b1, n);
        repeat (3) tick();
        chk("t5_queued", int'(evt_data_o), 6);
        pin[5] = 1'b1;
        repeat (8) tick();
        chk("t5_midcount", int'(level_o[5]), 0);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        chk("t5_rst_level", int'(level_o), 0);
        chk("t5_rst_rise", int'(rise_o), 0);
        chk("t5_rst_valid", int'(evt_valid_o), 0);
        chk("t5_rst_data", int'(evt_data_o), 0);
        chk("t5_rst_ovf", int'(evt_overflow_o), 0);
        rst_n = 1'b1;
        ready = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(k);
        wait_level(5, 1'b1, n);
        chk("t5_relatency", n, 18);
        chk("t5_level", int'(level_o), 'hFF);
        chk("t5_rise", int'(rise_o), 'hFF);
        repeat (12) tick();
        chk("t5_drained", int'(evt_valid_o), 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
